// File: rtl/mips_cache_pkg.sv
// Shared types and helpers for the MIPS direct-mapped data cache.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mips_cache_pkg;

    localparam int DEF_LINES          = 16;
    localparam int DEF_MEM_LATENCY    = 4;
    localparam int DEF_WRITE_ALLOCATE = 0;

    typedef enum logic [1:0] {
        IDLE,
        READ_MISS,
        WRITE_MEM
    } cache_state_t;

    // Lane 0 is the most significant byte (big-endian memory bus).
    typedef logic [0:3][7:0] byte_lanes_t;

    function automatic logic [31:0] lanes_to_word(input byte_lanes_t lanes);
        return {lanes[0], lanes[1], lanes[2], lanes[3]};
    endfunction

    function automatic byte_lanes_t word_to_lanes(input logic [31:0] word);
        byte_lanes_t lanes;
        lanes[0] = word[31:24];
        lanes[1] = word[23:16];
        lanes[2] = word[15:8];
        lanes[3] = word[7:0];
        return lanes;
    endfunction

endpackage

// File: rtl/mips_dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache, one word per line.
// Latency: read is combinational, write lands on the next rising edge.
// Backpressure: none; the single write port is always ready.
module mips_dcache_array
    import mips_cache_pkg::*;
#(
    parameter int LINES = DEF_LINES
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic [$clog2(LINES)-1:0]  rd_idx,
    output logic                      rd_valid,
    output logic [29-$clog2(LINES):0] rd_tag,
    output logic [31:0]               rd_data,
    input  logic                      wr_en,
    input  logic [$clog2(LINES)-1:0]  wr_idx,
    input  logic [29-$clog2(LINES):0] wr_tag,
    input  logic [31:0]               wr_data
);

    localparam int TW = 30 - $clog2(LINES);

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    // Only the valid bits need clearing; stale tag/data behind a clear bit are harmless.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/mips_dcache.sv
// Direct-mapped write-through data cache between the MIPS core and fixed-latency memory.
// Latency: load hit 0 cycles; load miss or any store completes MEM_LATENCY cycles after request.
// Backpressure: stall holds the core's request and PC while memory is being accessed.
module mips_dcache
    import mips_cache_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int MEM_LATENCY    = DEF_MEM_LATENCY,
    parameter int WRITE_ALLOCATE = DEF_WRITE_ALLOCATE
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        hit,
    output logic [31:0] mem_addr,
    output byte_lanes_t mem_data_in,
    input  byte_lanes_t mem_data_out,
    output logic        mem_write_en
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;
    localparam int CW = $clog2(MEM_LATENCY) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    cache_state_t  state;
    logic [CW-1:0] cnt;
    logic [29:0]   lat_waddr;
    logic [31:0]   lat_wdata;

    logic [IW-1:0] lk_idx;
    logic [TW-1:0] lk_tag;
    logic          arr_valid;
    logic [TW-1:0] arr_tag;
    logic [31:0]   arr_data;
    logic          line_hit;
    logic          done;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic [31:0]   mem_word;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

    // Outside IDLE the lookup follows the latch, since the core's inputs are not trusted there.
    assign lk_idx   = (state == IDLE) ? req_addr[IW+1:2]  : lat_waddr[IW-1:0];
    assign lk_tag   = (state == IDLE) ? req_addr[31:IW+2] : lat_waddr[29:IW];
    assign line_hit = arr_valid && (arr_tag == lk_tag);
    assign mem_word = lanes_to_word(mem_data_out);
    assign done     = (state != IDLE) && (cnt == '0);
    assign wr_en    = done && ((state == READ_MISS) || line_hit || (WRITE_ALLOCATE != 0));
    assign wr_data  = (state == READ_MISS) ? mem_word : lat_wdata;

    mips_dcache_array #(
        .LINES (LINES)
    ) u_array (
        .clk      (clk),
        .rst_b    (rst_b),
        .rd_idx   (lk_idx),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .wr_en    (wr_en),
        .wr_idx   (lat_waddr[IW-1:0]),
        .wr_tag   (lat_waddr[29:IW]),
        .wr_data  (wr_data)
    );

    always_comb begin
        hit   = (state == IDLE) && req_valid && line_hit;
        stall = 1'b0;
        rdata = '0;
        case (state)
            IDLE: begin
                stall = req_valid && (req_we || !line_hit);
                if (req_valid && !req_we && line_hit) begin
                    rdata = arr_data;
                end
            end
            READ_MISS: begin
                stall = (cnt != '0);
                if (cnt == '0) begin
                    rdata = mem_word;
                end
            end
            WRITE_MEM: begin
                stall = (cnt != '0);
            end
            default: ;
        endcase
    end

    // Memory-side outputs come from registered state only, so they are quiet in IDLE.
    assign mem_addr     = (state != IDLE) ? {lat_waddr, 2'b00} : '0;
    assign mem_write_en = (state == WRITE_MEM);
    assign mem_data_in  = (state == WRITE_MEM) ? word_to_lanes(lat_wdata) : '0;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_waddr <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stall) begin
                        lat_waddr <= req_addr[31:2];
                        lat_wdata <= req_wdata;
                        cnt       <= CNT_INIT;
                        state     <= req_we ? WRITE_MEM : READ_MISS;
                    end
                end
                READ_MISS, WRITE_MEM: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dcache.sv
// Directed self-checking bench for mips_dcache: one write-no-allocate and one write-allocate instance.
module tb_mips_dcache;
    import mips_cache_pkg::*;

    logic clk = 1'b0;
    logic rst_b;
    logic mem_init;
    always #5 clk = ~clk;

    logic        rv0, we0, rv1, we1;
    logic [31:0] a0, wd0, a1, wd1;
    logic [31:0] rd0, rd1, ma0, ma1;
    logic        st0, st1, h0, h1, wen0, wen1;
    byte_lanes_t mdi0, mdi1, mdo0, mdo1;

    int checks = 0;
    int errors = 0;
    byte_lanes_t last_lanes;

    mips_dcache #(.LINES(16), .MEM_LATENCY(4), .WRITE_ALLOCATE(0)) dut0 (
        .clk(clk), .rst_b(rst_b), .req_valid(rv0), .req_we(we0), .req_addr(a0),
        .req_wdata(wd0), .rdata(rd0), .stall(st0), .hit(h0), .mem_addr(ma0),
        .mem_data_in(mdi0), .mem_data_out(mdo0), .mem_write_en(wen0)
    );

    mips_dcache #(.LINES(16), .MEM_LATENCY(4), .WRITE_ALLOCATE(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .req_valid(rv1), .req_we(we1), .req_addr(a1),
        .req_wdata(wd1), .rdata(rd1), .stall(st1), .hit(h1), .mem_addr(ma1),
        .mem_data_in(mdi1), .mem_data_out(mdo1), .mem_write_en(wen1)
    );

    // Memory model: preloaded contents until a word is written, then the written word.
    function automatic logic [31:0] preload(input logic [11:0] addr);
        case (addr)
            12'h040: return 32'h11223344;
            12'h440: return 32'hCAFEF00D;
            12'h100: return 32'h55667788;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0]   mem0 [0:1023];
    logic [31:0]   mem1 [0:1023];
    logic [1023:0] written0, written1;

    always @(posedge clk) begin
        if (mem_init) begin
            written0 <= '0;
            written1 <= '0;
        end else begin
            if (wen0) begin
                mem0[ma0[11:2]]     <= {mdi0[0], mdi0[1], mdi0[2], mdi0[3]};
                written0[ma0[11:2]] <= 1'b1;
            end
            if (wen1) begin
                mem1[ma1[11:2]]     <= {mdi1[0], mdi1[1], mdi1[2], mdi1[3]};
                written1[ma1[11:2]] <= 1'b1;
            end
        end
    end

    assign mdo0 = written0[ma0[11:2]] ? mem0[ma0[11:2]] : preload({ma0[11:2], 2'b00});
    assign mdo1 = written1[ma1[11:2]] ? mem1[ma1[11:2]] : preload({ma1[11:2], 2'b00});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
        if (sel == 0) begin
            rv0 = v; we0 = we; a0 = a; wd0 = d;
        end else begin
            rv1 = v; we1 = we; a1 = a; wd1 = d;
        end
    endtask

    // Entered just after a falling edge; presents one request and follows it to completion.
    task automatic access(input int sel, input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_hit, input int exp_stalls, input logic [31:0] exp_rd,
                          input string tag);
        int n;
        int wens;
        n = 0;
        wens = 0;
        drive(sel, 1'b1, we, a, d);
        #1;
        chk({tag, " hit"}, 32'(sel != 0 ? h1 : h0), 32'(exp_hit));
        while ((sel != 0 ? st1 : st0) && n < 20) begin
            n++;
            if (sel != 0 ? wen1 : wen0) begin
                wens++;
                last_lanes = (sel != 0) ? mdi1 : mdi0;
            end
            @(negedge clk); #1;
        end
        if (sel != 0 ? wen1 : wen0) begin
            wens++;
            last_lanes = (sel != 0) ? mdi1 : mdi0;
        end
        chk({tag, " stall cycles"}, 32'(n), 32'(exp_stalls));
        chk({tag, " rdata"}, (sel != 0 ? rd1 : rd0), exp_rd);
        chk({tag, " write strobes"}, 32'(wens), we ? 32'd4 : 32'd0);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk); #1;
        chk({tag, " idle strobe"}, 32'(sel != 0 ? wen1 : wen0), 32'd0);
        chk({tag, " idle addr"}, (sel != 0 ? ma1 : ma0), 32'h0);
    endtask

    initial begin
        rst_b = 1'b0;
        mem_init = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        last_lanes = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset stall", 32'(st0), 32'd0);
        chk("reset hit", 32'(h0), 32'd0);
        chk("reset rdata", rd0, 32'h0);
        chk("reset mem_write_en", 32'(wen0), 32'd0);
        chk("reset mem_addr", ma0, 32'h0);
        chk("reset mem_data_in", 32'(mdi0), 32'h0);
        rst_b = 1'b1;
        mem_init = 1'b0;
        @(negedge clk); #1;

        access(0, 1'b0, 32'h40, 32'h0, 1'b0, 4, 32'h11223344, "cold load 0x40");
        access(0, 1'b0, 32'h40, 32'h0, 1'b1, 0, 32'h11223344, "hit load 0x40");
        access(0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 4, 32'h0, "store hit 0x40");
        chk("store lane 0", 32'(last_lanes[0]), 32'hDE);
        chk("store lane 1", 32'(last_lanes[1]), 32'hAD);
        chk("store lane 2", 32'(last_lanes[2]), 32'hBE);
        chk("store lane 3", 32'(last_lanes[3]), 32'hEF);
        access(0, 1'b0, 32'h40, 32'h0, 1'b1, 0, 32'hDEADBEEF, "load after store");
        access(0, 1'b0, 32'h440, 32'h0, 1'b0, 4, 32'hCAFEF00D, "conflict load 0x440");
        access(0, 1'b0, 32'h40, 32'h0, 1'b0, 4, 32'hDEADBEEF, "refetch 0x40");

        access(0, 1'b1, 32'h100, 32'h12345678, 1'b0, 4, 32'h0, "no-alloc store miss");
        access(0, 1'b0, 32'h100, 32'h0, 1'b0, 4, 32'h12345678, "no-alloc load");
        access(1, 1'b1, 32'h100, 32'hA5A5A5A5, 1'b0, 4, 32'h0, "alloc store miss");
        access(1, 1'b0, 32'h100, 32'h0, 1'b1, 0, 32'hA5A5A5A5, "alloc load");

        access(0, 1'b0, 32'h40, 32'h0, 1'b0, 4, 32'hDEADBEEF, "reload 0x40");
        access(0, 1'b0, 32'h40, 32'h0, 1'b1, 0, 32'hDEADBEEF, "rehit 0x40");

        // Reset lands on the second cycle of a read miss to 0x84.
        drive(0, 1'b1, 1'b0, 32'h84, 32'h0);
        #1;
        chk("pre-reset miss stall", 32'(st0), 32'd1);
        @(negedge clk); #1;
        rst_b = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk); #1;
        chk("mid-miss reset stall", 32'(st0), 32'd0);
        chk("mid-miss reset mem_write_en", 32'(wen0), 32'd0);
        chk("mid-miss reset mem_addr", ma0, 32'h0);
        chk("mid-miss reset rdata", rd0, 32'h0);
        rst_b = 1'b1;
        @(negedge clk); #1;
        access(0, 1'b0, 32'h40, 32'h0, 1'b0, 4, 32'hDEADBEEF, "load after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
